// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory stage.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/mem_wb_regs.sv
// MEM/WB pipeline register: bubble clears control only, loadRead gates the read-data field.
module mem_wb_regs
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic         loadRead,
  input  logic [31:0]  aluOut,
  input  logic [31:0]  readData,
  input  logic [4:0]   rd,
  input  mem_wb_ctrl_t ctrl,
  output logic [31:0]  aluOutQ,
  output logic [31:0]  readDataQ,
  output logic [4:0]   rdQ,
  output mem_wb_ctrl_t ctrlQ
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      aluOutQ   <= '0;
      readDataQ <= '0;
      rdQ       <= '0;
      ctrlQ     <= '0;
    end else if (bubble) begin
      ctrlQ <= '0;
    end else if (load) begin
      aluOutQ <= aluOut;
      rdQ     <= rd;
      ctrlQ   <= ctrl;
      if (loadRead) begin
        readDataQ <= readData;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory bus sequencing, pipeline freeze and branch select.
//
// state | meaning
// IDLE  | evaluate EX/MEM; launch aligned access, flag misaligned, else pass through
// REQ   | dmem_req held with captured addr/we/wdata until gnt or timeout
// WAIT  | read granted, waiting for rvalid or timeout
// DONE  | stall released; MEM/WB takes the finished access, EX/MEM advances
module mem_stage_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15  // must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_pc_branch,
  input  logic        in_zero,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        in_branch,
  input  logic        in_mem_write,
  input  logic        in_mem_read,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic        err,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_read_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdataQ;
  logic             timedOut;

  logic         memOp;
  logic         aligned;
  logic         accessStart;
  logic         misaligned;
  logic         stallRaw;
  mem_wb_ctrl_t wbCtrlIn;
  mem_wb_ctrl_t wbCtrlQ;

  assign memOp       = in_mem_read | in_mem_write;
  assign aligned     = (in_alu_out & WORD_ALIGN_MASK) == '0;
  assign accessStart = (state == IDLE) && memOp && aligned;
  assign misaligned  = (state == IDLE) && memOp && !aligned;

  always_comb begin
    stallRaw = 1'b0;
    case (state)
      IDLE:      stallRaw = accessStart;
      REQ, WAIT: stallRaw = 1'b1;
      default:   stallRaw = 1'b0;
    endcase
  end

  assign stall     = stallRaw & rst;
  assign pc_src    = in_branch & in_zero & ~stall & rst;
  assign pc_branch = in_pc_branch;

  // Aborted or misaligned accesses must never retire a register write.
  assign wbCtrlIn.reg_write  = in_reg_write & ~misaligned & ~((state == DONE) & timedOut);
  assign wbCtrlIn.mem_to_reg = in_mem_to_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdataQ     <= '0;
      timedOut   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          timedOut <= 1'b0;
          if (accessStart) begin
            dmem_req   <= 1'b1;
            dmem_we    <= in_mem_write;
            dmem_addr  <= in_alu_out;
            dmem_wdata <= in_store_data;
            state      <= REQ;
          end else if (misaligned) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            dmem_req <= 1'b0;
            err      <= 1'b1;
            rdataQ   <= '0;
            timedOut <= 1'b1;
            state    <= DONE;
          end else if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            rdataQ   <= '0;
            timedOut <= 1'b1;
            state    <= DONE;
          end else if (dmem_rvalid) begin
            rdataQ <= dmem_rdata;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_regs uMemWb (
    .clk       (clk),
    .rst       (rst),
    .load      (~stall),
    .bubble    (stall),
    .loadRead  (state == DONE),
    .aluOut    (in_alu_out),
    .readData  (rdataQ),
    .rd        (in_rd),
    .ctrl      (wbCtrlIn),
    .aluOutQ   (wb_alu_out),
    .readDataQ (wb_read_data),
    .rdQ       (wb_rd),
    .ctrlQ     (wbCtrlQ)
  );

  assign wb_reg_write  = wbCtrlQ.reg_write;
  assign wb_mem_to_reg = wbCtrlQ.mem_to_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table for pass-through/branch, sequences for bus accesses.
module tb_mem_stage_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_pc_branch, in_alu_out, in_store_data;
  logic        in_zero, in_reg_write, in_mem_to_reg, in_branch, in_mem_write, in_mem_read;
  logic [4:0]  in_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pc_src, err;
  logic [31:0] pc_branch, wb_alu_out, wb_read_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_mem_to_reg;

  int checks = 0;
  int errors = 0;

  int reqCnt, stallCnt, errCnt, bubbleCnt, pcCnt, busBad;
  logic [31:0] expAddr, expData;
  logic        expWe;

  mem_stage_ctrl #(.TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .in_pc_branch(in_pc_branch), .in_zero(in_zero), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch), .err(err),
    .wb_alu_out(wb_alu_out), .wb_read_data(wb_read_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    in_mem_read = 0; in_mem_write = 0; in_branch = 0; in_zero = 0;
    in_reg_write = 0; in_mem_to_reg = 0; in_alu_out = 0; in_rd = 0;
    in_store_data = 0; in_pc_branch = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Runs n cycles of bus activity; gnt pulses at cycle gntAt, rvalid is high from
  // cycle 1 up to rvalidAt with junk data before rvalidAt (must be ignored).
  task automatic runCycles(input int n, input int gntAt, input int rvalidAt, input logic [31:0] rdata);
    reqCnt = 0; stallCnt = 0; errCnt = 0; bubbleCnt = 0; pcCnt = 0; busBad = 0;
    for (int k = 0; k < n; k++) begin
      dmem_gnt    = (k == gntAt);
      dmem_rvalid = (k >= 1) && (k <= rvalidAt);
      dmem_rdata  = (k == rvalidAt) ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      if (dmem_req) begin
        reqCnt++;
        if (dmem_addr !== expAddr || dmem_wdata !== expData || dmem_we !== expWe) busBad++;
      end
      if (stall) stallCnt++;
      if (err) errCnt++;
      if (pc_src) pcCnt++;
      if (k >= 1 && !wb_reg_write) bubbleCnt++;
      step();
    end
    nop();
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw, m2r, br, zero;
    logic [31:0] pcb;
    logic        expPcSrc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h1111_1111, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1};
    vecs[1] = '{32'hA5A5_A5A5, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b0};
    vecs[2] = '{32'h0000_0000, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0048, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 5'd17, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b1};
    vecs[4] = '{32'h0000_1234, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 1'b0};

    // Reset with a live memop and branch on the inputs: stall/pc_src must stay low.
    nop();
    rst = 0;
    in_mem_read = 1; in_alu_out = 32'h100; in_branch = 1; in_zero = 1;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_pc_src", {31'd0, pc_src}, 0);
    step();
    step();
    check("rst_bus", {dmem_req, dmem_we, err}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb_alu", wb_alu_out, 0);
    check("rst_wb_rdata", wb_read_data, 0);
    check("rst_wb_ctrl", {wb_rd, wb_reg_write, wb_mem_to_reg}, 0);
    nop();
    rst = 1;

    // Non-memory pass-through and same-cycle branch select.
    for (int i = 0; i < 5; i++) begin
      in_alu_out = vecs[i].alu; in_rd = vecs[i].rd; in_reg_write = vecs[i].rw;
      in_mem_to_reg = vecs[i].m2r; in_branch = vecs[i].br; in_zero = vecs[i].zero;
      in_pc_branch = vecs[i].pcb;
      @(negedge clk);
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 0);
      check($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].expPcSrc});
      check($sformatf("v%0d_pc_branch", i), pc_branch, vecs[i].pcb);
      step();
      check($sformatf("v%0d_wb_alu", i), wb_alu_out, vecs[i].alu);
      check($sformatf("v%0d_wb_ctrl", i), {27'd0, wb_rd, wb_reg_write, wb_mem_to_reg},
            {27'd0, vecs[i].rd, vecs[i].rw, vecs[i].m2r});
      check($sformatf("v%0d_wb_rdata", i), wb_read_data, 0);
    end

    // Load: gnt in REQ, rvalid next cycle; branch held high to check suppression.
    nop();
    in_mem_read = 1; in_alu_out = 32'h100; in_rd = 5; in_reg_write = 1; in_mem_to_reg = 1;
    in_branch = 1; in_zero = 1;
    expAddr = 32'h100; expData = 0; expWe = 0;
    runCycles(4, 1, 2, 32'hDEAD_BEEF);
    check("ld_stall_cycles", stallCnt, 3);
    check("ld_req_cycles", reqCnt, 1);
    check("ld_bus_fields", busBad, 0);
    check("ld_bubbles", bubbleCnt, 3);
    check("ld_pc_src_cycles", pcCnt, 1);
    check("ld_err_cycles", errCnt, 0);
    check("ld_wb_rdata", wb_read_data, 32'hDEAD_BEEF);
    check("ld_wb_alu", wb_alu_out, 32'h100);
    check("ld_wb_ctrl", {27'd0, wb_rd, wb_reg_write, wb_mem_to_reg}, {27'd0, 5'd5, 1'b1, 1'b1});
    step();
    check("nop_keeps_rdata", wb_read_data, 32'hDEAD_BEEF);

    // Store with gnt delayed 3 cycles.
    in_mem_write = 1; in_alu_out = 32'h200; in_store_data = 32'h1234_5678;
    expAddr = 32'h200; expData = 32'h1234_5678; expWe = 1;
    runCycles(6, 4, -1, 0);
    check("st_req_cycles", reqCnt, 4);
    check("st_stall_cycles", stallCnt, 5);
    check("st_bus_fields", busBad, 0);
    check("st_err_cycles", errCnt, 0);
    check("st_wb_alu", wb_alu_out, 32'h200);
    check("st_wb_reg_write", {31'd0, wb_reg_write}, 0);

    // Misaligned read: no bus access, single err pulse, no register write.
    in_mem_read = 1; in_alu_out = 32'h102; in_rd = 7; in_reg_write = 1; in_mem_to_reg = 1;
    runCycles(1, -1, -1, 0);
    check("mis_stall_cycles", stallCnt, 0);
    check("mis_err_now", {31'd0, err}, 1);
    check("mis_wb_reg_write", {31'd0, wb_reg_write}, 0);
    check("mis_wb_rd_alu", {wb_rd, wb_alu_out[26:0]}, {5'd7, 27'h102});
    @(negedge clk);
    check("mis_req", {31'd0, dmem_req}, 0);
    step();
    check("mis_err_cleared", {31'd0, err}, 0);

    // Timeout: gnt never arrives.
    in_mem_read = 1; in_alu_out = 32'h300; in_rd = 9; in_reg_write = 1; in_mem_to_reg = 1;
    expAddr = 32'h300; expData = 0; expWe = 0;
    runCycles(17, -1, -1, 0);
    check("to_req_cycles", reqCnt, 15);
    check("to_stall_cycles", stallCnt, 16);
    check("to_err_cycles", errCnt, 1);
    check("to_bus_fields", busBad, 0);
    check("to_wb_reg_write", {31'd0, wb_reg_write}, 0);
    check("to_wb_rdata", wb_read_data, 0);
    check("to_wb_rd", {27'd0, wb_rd}, 9);
    in_branch = 1; in_zero = 1;
    @(negedge clk);
    check("to_back_idle", {30'd0, stall, pc_src}, {30'd0, 1'b0, 1'b1});
    step();
    nop();

    // Reset asserted while waiting for rvalid.
    in_mem_read = 1; in_alu_out = 32'h400; in_rd = 4; in_reg_write = 1; in_mem_to_reg = 1;
    expAddr = 32'h400; expData = 0; expWe = 0;
    runCycles(3, 1, -1, 0);
    in_mem_read = 1; in_alu_out = 32'h400;
    rst = 0;
    @(negedge clk);
    check("rw_stall_in_rst", {31'd0, stall}, 0);
    step();
    nop();
    rst = 1;
    @(negedge clk);
    check("rw_req", {31'd0, dmem_req}, 0);
    check("rw_stall", {31'd0, stall}, 0);
    check("rw_wb", {wb_alu_out, wb_read_data}, 0);
    check("rw_wb_ctrl", {27'd0, wb_rd, wb_reg_write, wb_mem_to_reg}, 0);
    in_alu_out = 32'h55; in_rd = 2; in_reg_write = 1;
    step();
    check("rw_idle_passthru", wb_alu_out, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the pipelined RISC-V core. It consumes the EX/MEM pipeline register outputs and performs the data-memory access over a request/grant/response bus. It freezes the upstream pipeline while an access is in flight, resolves the taken-branch select, and holds the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- TIMEOUT_CYC, 15: maximum cycles spent in REQ+WAIT before the access is aborted; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_pc_branch  in  32  branch target from EX/MEM.
- in_zero  in  1  ALU zero flag.
- in_alu_out  in  32  ALU result; this is the memory address for loads/stores.
- in_store_data  in  32  store data (rs2).
- in_rd  in  5  destination register.
- in_reg_write, in_mem_to_reg, in_branch, in_mem_write, in_mem_read  in  1 each  control bits.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  write data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- stall  out  1  drives en low on PC, IF/ID, ID/EX and EX/MEM.
- pc_src  out  1  select branch target.
- pc_branch  out  32  equals in_pc_branch.
- err  out  1  one-cycle pulse on misaligned access or timeout.
- wb_alu_out, wb_read_data  out  32 each  MEM/WB data.
- wb_rd  out  5  MEM/WB destination register.
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control bits.

## Operation
- memop = in_mem_read | in_mem_write. If both bits are set, the access is a write.
- aligned = (in_alu_out[1:0] == 0).
- FSM states:
  - IDLE, the reset state. If memop & aligned: capture address, wdata and we; stall=1; go to REQ. If memop & ~aligned: no bus access; err=1 for one cycle; stall=0; MEM/WB loads with wb_reg_write forced 0. Otherwise pass-through.
  - REQ: dmem_req=1, holding the captured addr/we/wdata stable. On gnt: a write goes to DONE, a read goes to WAIT.
  - WAIT: on dmem_rvalid, capture dmem_rdata and go to DONE.
  - DONE: stall=0. MEM/WB loads in_alu_out, the captured read data, in_rd, in_reg_write and in_mem_to_reg. Next state is IDLE.
- Timeout: the counter is cleared in IDLE and increments each cycle in REQ/WAIT. On reaching TIMEOUT_CYC: dmem_req drops, err pulses, read data becomes 0, wb_reg_write is forced 0, and the FSM goes to DONE.
- stall = 1 in IDLE when memop & aligned, and in REQ and WAIT; otherwise 0. stall is forced 0 while rst=0.
- While stall=1, MEM/WB loads a bubble: wb_reg_write=0 and wb_mem_to_reg=0, with data fields unchanged.
- pc_src = in_branch & in_zero & ~stall & rst.
- For non-memory instructions, MEM/WB loads from the in_* signals every cycle with wb_read_data unchanged.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE and counter=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - err=0.
  - All wb_* outputs = 0.
- Reset mid-access abandons the transaction. The bus slave must tolerate a dropped request.
- Non-memory instruction: 1-cycle stage latency, with no stall.
- Write with immediate gnt: 3 cycles (IDLE, REQ, DONE), stall high for 2 cycles.
- Read with immediate gnt and rvalid on the next cycle: 4 cycles, stall high for 3 cycles.
- dmem_rvalid is earliest the cycle after gnt. rvalid seen in REQ is ignored.
- EX/MEM advances at the end of DONE. The next instruction is therefore evaluated fresh in IDLE, and back-to-back memops each incur the full sequence.
- dmem_req, dmem_addr, dmem_we and dmem_wdata are registered. stall and pc_src are combinational.

## Structure
- Package core_pkg holds:
  - the mem_state_e enum (IDLE, REQ, WAIT, DONE);
  - the word-alignment mask constant;
  - the MEM/WB control struct (reg_write, mem_to_reg).
- Sub-module mem_wb_regs holds the MEM/WB register, with load, bubble and synchronous active-low reset inputs. The FSM, counter and bus logic stay in mem_stage_ctrl.

## Test plan
- Load: in_mem_read=1, in_alu_out=0x100, in_rd=5, gnt in REQ, rvalid next cycle with rdata=0xDEADBEEF. Required: stall high for 3 cycles; wb_read_data=0xDEADBEEF, wb_rd=5, wb_mem_to_reg=1 after DONE; one bubble on wb_reg_write per stall cycle.
- Store: in_mem_write=1, addr 0x200, data 0x12345678, gnt delayed 3 cycles. Required: dmem_req held 4 cycles with we=1 and stable addr/data; stall high for 5 cycles.
- Misaligned: addr 0x102 with in_mem_read=1. Required: no dmem_req, err pulses 1 cycle, stall=0, wb_reg_write=0.
- Timeout: gnt never asserted with TIMEOUT_CYC=15. Required: dmem_req drops after 15 cycles, err pulses, wb_reg_write=0, FSM returns to IDLE.
- Branch: in_branch=1, in_zero=1, pc_branch=0x40. Required: pc_src=1 in the same cycle. The same inputs during a stall give pc_src=0.
- Reset asserted in WAIT. Required: next cycle dmem_req=0, stall=0, all wb_* outputs=0, state=IDLE.
